// File: rtl/sram_pkg.sv
// sram_pkg: shared sequencer states, requester port indices and SRAM widths
package sram_pkg;
  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;
  localparam logic PORT_MEM = 1'b0;
  localparam logic PORT_IF = 1'b1;
  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
endpackage

// File: rtl/sram_access_seq.sv
// sram_access_seq: runs one fixed-length SRAM transaction from latched request fields
module sram_access_seq
  import sram_pkg::*;
#(
  parameter int ACCESS_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_we,
  input  logic [SRAM_AW-1:0] i_addr,
  input  logic [SRAM_DW-1:0] i_wdata,
  input  logic [SRAM_DW-1:0] i_dq,
  output logic               o_idle,
  output logic               o_done,
  output logic               o_busy,
  output logic [SRAM_DW-1:0] o_rdata,
  output logic [SRAM_AW-1:0] o_addr,
  output logic [SRAM_DW-1:0] o_dq,
  output logic               o_dq_oe,
  output logic               o_we_n,
  output logic               o_ce_n,
  output logic               o_oe_n
);
  localparam logic [3:0] LAST = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] WE_LAST = 4'(ACCESS_CYCLES - 2);
  state_t r_state, w_next;
  logic [3:0] r_cnt;
  logic r_we;
  logic [SRAM_AW-1:0] r_addr;
  logic [SRAM_DW-1:0] r_wdata, r_rdata;
  logic w_acc, w_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt <= 4'd0;
      r_we <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= (w_acc && !w_last) ? r_cnt + 4'd1 : 4'd0;
      if (i_start && o_idle) {r_we, r_addr, r_wdata} <= {i_we, i_addr, i_wdata};
      if (w_last && !r_we) r_rdata <= i_dq;
    end
  end

  // WE_N low only for cnt 1..ACCESS_CYCLES-2 leaves one setup and one hold cycle
  always_comb begin
    w_acc = r_state == ACCESS;
    w_last = w_acc && r_cnt == LAST;
    w_next = r_state == IDLE ? (i_start ? ACCESS : IDLE) : r_state == ACCESS ? (w_last ? ACK : ACCESS) : IDLE;
    o_idle = r_state == IDLE;
    o_done = r_state == ACK;
    o_busy = r_state != IDLE;
    o_rdata = r_rdata;
    o_addr = r_addr;
    o_dq = r_wdata;
    o_dq_oe = w_acc && r_we;
    o_ce_n = !w_acc;
    o_oe_n = !(w_acc && !r_we);
    o_we_n = !(w_acc && r_we && r_cnt != 4'd0 && r_cnt <= WE_LAST);
  end
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one external 16-bit SRAM between MEM (port 0) and IF (port 1)
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int ACCESS_CYCLES = 4,
  parameter bit FIXED_PRIO = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic               we0,
  input  logic [SRAM_AW-1:0] addr0,
  input  logic [SRAM_DW-1:0] wdata0,
  output logic               ack0,
  input  logic               req1,
  input  logic               we1,
  input  logic [SRAM_AW-1:0] addr1,
  input  logic [SRAM_DW-1:0] wdata1,
  output logic               ack1,
  output logic [SRAM_DW-1:0] rdata,
  output logic               busy,
  inout  wire  [SRAM_DW-1:0] SRAM_DATA,
  output logic [SRAM_AW-1:0] SRAM_ADDRESS,
  output logic               SRAM_WE_N_O,
  output logic               SRAM_CE_N_O,
  output logic               SRAM_OE_N_O,
  output logic               SRAM_UB_N_O,
  output logic               SRAM_LB_N_O
);
  logic r_grant;
  logic w_idle, w_done, w_start, w_pick, w_dq_oe;
  logic [SRAM_DW-1:0] w_dq;

  // r_grant doubles as last_grant: it is only rewritten when a new access starts
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_grant <= PORT_IF;
    else if (w_start) r_grant <= w_pick;
  end

  always_comb begin
    w_pick = (!FIXED_PRIO && req0 && req1) ? ~r_grant : (req0 ? PORT_MEM : PORT_IF);
    w_start = w_idle && (req0 || req1);
    ack0 = w_done && r_grant == PORT_MEM;
    ack1 = w_done && r_grant == PORT_IF;
    SRAM_UB_N_O = 1'b0;
    SRAM_LB_N_O = 1'b0;
  end

  assign SRAM_DATA = w_dq_oe ? w_dq : 'z;

  sram_access_seq #(.ACCESS_CYCLES(ACCESS_CYCLES)) u_seq (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_we    (w_pick ? we1 : we0),
    .i_addr  (w_pick ? addr1 : addr0),
    .i_wdata (w_pick ? wdata1 : wdata0),
    .i_dq    (SRAM_DATA),
    .o_idle  (w_idle),
    .o_done  (w_done),
    .o_busy  (busy),
    .o_rdata (rdata),
    .o_addr  (SRAM_ADDRESS),
    .o_dq    (w_dq),
    .o_dq_oe (w_dq_oe),
    .o_we_n  (SRAM_WE_N_O),
    .o_ce_n  (SRAM_CE_N_O),
    .o_oe_n  (SRAM_OE_N_O)
  );
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: fixed-priority (g=0) and round-robin (g=1) arbiters, each on its own SRAM model
module tb_sram_arbiter;
  localparam int AC = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] req0, we0, req1, we1;
  logic [17:0] addr0 [2], addr1 [2];
  logic [15:0] wdata0 [2], wdata1 [2];
  wire [1:0] ack0, ack1, busy, we_n, ce_n, oe_n, ub_n, lb_n;
  wire [15:0] rdata [2];
  wire [17:0] sa [2];
  wire [15:0] bus [2];
  logic [15:0] mem [2][0:262143];
  logic [15:0] ref_mem [int];
  int last [2];
  logic [15:0] last_rd [2];
  logic [17:0] pool [8];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    wire [15:0] dq;
    for (genvar b = 0; b < 16; b++) begin : g_pu
      pullup (dq[b]);
    end
    assign dq = (!oe_n[g] && !ce_n[g] && we_n[g]) ? mem[g][sa[g]] : 16'hzzzz;
    assign bus[g] = dq;
    sram_arbiter #(.ACCESS_CYCLES(AC), .FIXED_PRIO(g == 0)) u_dut (
      .clk(clk), .rst(rst),
      .req0(req0[g]), .we0(we0[g]), .addr0(addr0[g]), .wdata0(wdata0[g]), .ack0(ack0[g]),
      .req1(req1[g]), .we1(we1[g]), .addr1(addr1[g]), .wdata1(wdata1[g]), .ack1(ack1[g]),
      .rdata(rdata[g]), .busy(busy[g]), .SRAM_DATA(dq), .SRAM_ADDRESS(sa[g]),
      .SRAM_WE_N_O(we_n[g]), .SRAM_CE_N_O(ce_n[g]), .SRAM_OE_N_O(oe_n[g]),
      .SRAM_UB_N_O(ub_n[g]), .SRAM_LB_N_O(lb_n[g])
    );
  end

  always @(posedge clk)
    for (int k = 0; k < 2; k++)
      if (!we_n[k] && !ce_n[k]) mem[k][sa[k]] <= bus[k];

  function automatic int key(input int k, input logic [17:0] a);
    return (k << 18) + int'(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One arbitration round: m selects requesting ports; predicted from the timing rules
  task automatic run(input int k, input logic [1:0] m, input logic [1:0] w, input logic [17:0] a0,
                     input logic [17:0] a1, input logic [15:0] d0, input logic [15:0] d1);
    logic [17:0] a [2];
    logic [15:0] d [2];
    int ord [2];
    int ns, j, c, p;
    a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
    ord[0] = (m == 2'b10) ? 1 : (m == 2'b11 && k == 1) ? 1 - last[k] : 0;
    ord[1] = 1 - ord[0];
    ns = (m == 2'b11) ? 2 : 1;
    req0[k] = m[0]; we0[k] = w[0]; addr0[k] = a0; wdata0[k] = d0;
    req1[k] = m[1]; we1[k] = w[1]; addr1[k] = a1; wdata1[k] = d1;
    for (int n = 1; n <= ns * (AC + 2); n++) begin
      @(negedge clk);
      j = (n - 1) / (AC + 2);
      c = n - j * (AC + 2);
      p = ord[j];
      if (c <= AC) begin
        chk("acc_ce_n", ce_n[k], 0);
        chk("acc_busy", busy[k], 1);
        chk("acc_addr", sa[k], a[p]);
        chk("acc_oe_n", oe_n[k], w[p]);
        chk("acc_we_n", we_n[k], (w[p] && c >= 2 && c <= AC - 1) ? 0 : 1);
        chk("acc_noack", {ack1[k], ack0[k]}, 0);
        if (w[p]) chk("acc_bus", bus[k], d[p]);
        if (c == 1) begin
          if (p == 1) begin addr1[k] = 18'($urandom); wdata1[k] = 16'($urandom); we1[k] = ~we1[k]; end
          else begin addr0[k] = 18'($urandom); wdata0[k] = 16'($urandom); we0[k] = ~we0[k]; end
        end
      end else if (c == AC + 1) begin
        chk("ack_port", {ack1[k], ack0[k]}, p ? 2 : 1);
        chk("ack_pins", {we_n[k], ce_n[k], oe_n[k]}, 3'b111);
        chk("ack_bus_z", bus[k], 16'hFFFF);
        chk("ack_busy", busy[k], 1);
        if (w[p]) ref_mem[key(k, a[p])] = d[p];
        else begin
          last_rd[k] = ref_mem[key(k, a[p])];
          chk("ack_rdata", rdata[k], last_rd[k]);
        end
        last[k] = p;
        if (p == 1) req1[k] = 1'b0; else req0[k] = 1'b0;
      end else begin
        chk("idle_busy", busy[k], 0);
        chk("idle_noack", {ack1[k], ack0[k]}, 0);
        chk("idle_ce_n", ce_n[k], 1);
        chk("idle_rdata_hold", rdata[k], last_rd[k]);
      end
    end
  endtask

  initial begin
    int k, j, c, first;
    logic [1:0] m, w;
    req0 = '0; we0 = '0; req1 = '0; we1 = '0;
    for (int i = 0; i < 2; i++) begin
      addr0[i] = '0; addr1[i] = '0; wdata0[i] = '0; wdata1[i] = '0;
      last[i] = 1; last_rd[i] = '0;
    end
    for (int i = 0; i < 8; i++) pool[i] = 18'h100 + 18'(i);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ack", {ack1[i], ack0[i]}, 0);
      chk("rst_busy", busy[i], 0);
      chk("rst_rdata", rdata[i], 0);
      chk("rst_addr", sa[i], 0);
      chk("rst_pins", {we_n[i], ce_n[i], oe_n[i]}, 3'b111);
      chk("rst_bus_z", bus[i], 16'hFFFF);
      chk("rst_ub_lb", {ub_n[i], lb_n[i]}, 0);
    end
    rst = 1'b1;
    @(negedge clk);
    run(0, 2'b01, 2'b01, 18'h10, 18'h0, 16'hBEEF, 16'h0);
    for (int i = 0; i < 2; i++) begin
      run(i, 2'b01, 2'b01, 18'h1, 18'h0, 16'hA001, 16'h0);
      run(i, 2'b10, 2'b10, 18'h0, 18'h2, 16'h0, 16'hA002);
    end
    run(0, 2'b01, 2'b00, 18'h10, 18'h0, 16'h0, 16'h0);
    run(0, 2'b10, 2'b10, 18'h0, 18'h3FFFF, 16'h0, 16'h1234);
    chk("mem_updated", mem[0][18'h3FFFF], 16'h1234);
    run(0, 2'b01, 2'b00, 18'h3FFFF, 18'h0, 16'h0, 16'h0);
    run(0, 2'b11, 2'b00, 18'h1, 18'h2, 16'h0, 16'h0);
    run(1, 2'b01, 2'b00, 18'h1, 18'h0, 16'h0, 16'h0);
    req0[1] = 1'b1; we0[1] = 1'b1; addr0[1] = 18'h500; wdata0[1] = 16'h5A5A;
    repeat (3) @(negedge clk);
    chk("pre_rst_we_n", we_n[1], 0);
    chk("pre_rst_bus", bus[1], 16'h5A5A);
    #2 rst = 1'b0;
    req0[1] = 1'b0;
    #1;
    chk("arst_pins", {we_n[1], ce_n[1], oe_n[1]}, 3'b111);
    chk("arst_bus_z", bus[1], 16'hFFFF);
    chk("arst_busy", busy[1], 0);
    chk("arst_rdata", rdata[1], 0);
    for (int i = 0; i < 2; i++) begin last[i] = 1; last_rd[i] = '0; end
    repeat (2) begin
      @(negedge clk);
      chk("arst_noack", {ack1[1], ack0[1]}, 0);
    end
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_noack", {ack1[1], ack0[1]}, 0);
      chk("post_rst_busy", busy[1], 0);
    end
    run(1, 2'b10, 2'b00, 18'h0, 18'h2, 16'h0, 16'h0);
    first = 1 - last[1];
    req0[1] = 1'b1; req1[1] = 1'b1; we0[1] = 1'b0; we1[1] = 1'b0; addr0[1] = 18'h1; addr1[1] = 18'h2;
    for (int n = 1; n <= 4 * (AC + 2); n++) begin
      @(negedge clk);
      j = (n - 1) / (AC + 2);
      c = n - j * (AC + 2);
      if (c == AC + 1) begin
        chk("rr_ack", {ack1[1], ack0[1]}, ((j % 2) ^ first) ? 2 : 1);
        last_rd[1] = ref_mem[key(1, ((j % 2) ^ first) ? 18'h2 : 18'h1)];
        chk("rr_rdata", rdata[1], last_rd[1]);
        last[1] = (j % 2) ^ first;
        if (j == 3) begin req0[1] = 1'b0; req1[1] = 1'b0; end
      end else chk("rr_noack", {ack1[1], ack0[1]}, 0);
    end
    for (int i = 0; i < 8; i++)
      for (int q = 0; q < 2; q++) begin
        m = (i % 2) ? 2'b10 : 2'b01;
        run(q, m, m, pool[i], pool[i], 16'($urandom_range(0, 65534)), 16'($urandom_range(0, 65534)));
      end
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 1);
      m = 2'($urandom_range(1, 3));
      w = 2'($urandom);
      run(k, m, w, pool[$urandom_range(0, 7)], pool[$urandom_range(0, 7)],
          16'($urandom_range(0, 65534)), 16'($urandom_range(0, 65534)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
Shares the single external 16-bit SRAM between two requesters: port 0 (MEM stage load/store) and port 1 (instruction fetch / loader).
- Sequences each access as a fixed multi-cycle transaction: address setup, write-enable pulse or read sample, then a single-cycle ack back to the winning requester.
- Sole driver of all SRAM pins; sits between the pipeline stages and the board SRAM.

Parameters:
ACCESS_CYCLES, 4, cycles the SRAM pins are held per access; legal range 3..15.
FIXED_PRIO, 1, 1 = port 0 always wins contention; 0 = round-robin between ports.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
req0  input  1  port 0 request; held until ack0
we0  input  1  port 0 write (1) / read (0)
addr0  input  18  port 0 word address
wdata0  input  16  port 0 write data
ack0  output  1  port 0 single-cycle completion pulse
req1, we1, addr1, wdata1, ack1: same as port 0, for port 1
rdata  output  16  read data, valid in the ack cycle, held until the next read completes
busy  output  1  high whenever an access is in flight
SRAM_DATA  inout  16  SRAM data bus
SRAM_ADDRESS  output  18  SRAM address
SRAM_WE_N_O  output  1  write enable, active-low
SRAM_CE_N_O  output  1  chip enable, active-low
SRAM_OE_N_O  output  1  output enable, active-low
SRAM_UB_N_O  output  1  upper byte enable, tied 0
SRAM_LB_N_O  output  1  lower byte enable, tied 0

Behaviour:
- Reset (rst low, asynchronous): state IDLE, cnt=0, last_grant=1, ack0=ack1=0, rdata=0, busy=0.
  - SRAM_ADDRESS=0; WE_N=1, CE_N=1, OE_N=1; SRAM_DATA high-Z.
  - Reset mid-access aborts immediately; no ack is issued.
- States: IDLE, ACCESS, ACK.
- IDLE:
  - If no request, stay in IDLE.
  - Otherwise grant one port. FIXED_PRIO=1: port 0 wins. FIXED_PRIO=0, both requesting: the port != last_grant wins. Single requester: that port wins.
  - Latch grant, we, addr and wdata into internal registers. Set cnt=0, last_grant=grant. Go to ACCESS.
- ACCESS (cnt runs 0..ACCESS_CYCLES-1):
  - All pins are driven from the latched registers; requester inputs may change freely after the grant.
  - CE_N=0 throughout; busy=1.
  - Read: OE_N=0, WE_N=1, bus high-Z. On cnt==ACCESS_CYCLES-1, register SRAM_DATA into rdata.
  - Write: OE_N=1 and the bus driven with the latched wdata for the whole state. WE_N=0 only while 1 <= cnt <= ACCESS_CYCLES-2, giving one cycle of address/data setup and one of hold.
  - On cnt==ACCESS_CYCLES-1, go to ACK.
- ACK:
  - Pulse ack of the granted port for exactly one cycle; rdata is valid in this cycle for reads.
  - Pins return to idle levels (CE_N=1, WE_N=1, OE_N=1, bus high-Z); busy=1.
  - Next state is always IDLE.
- Latency: request sampled in IDLE at edge t gives ack at edge t+ACCESS_CYCLES+1. Back-to-back throughput is one access per ACCESS_CYCLES+2 cycles.
- Requester rule: req must drop in the cycle after its ack. A req still high in IDLE is treated as a new access.
- Simultaneous events:
  - A request arriving in ACCESS or ACK waits; it is arbitrated in the next IDLE.
  - The loser of an arbitration keeps req high and is served next; with FIXED_PRIO=0 it cannot be starved.
- ack0 and ack1 are never high together.
- The bus is never driven in IDLE, in ACK, or during a read, so there is no contention with the SRAM.

Decomposition:
- Shared package sram_pkg holds:
  - state enum (IDLE, ACCESS, ACK)
  - port index constants (PORT_MEM=0, PORT_IF=1)
  - widths SRAM_AW=18 and SRAM_DW=16
- One sub-module, sram_access_seq: takes start/we/addr/wdata and provides cnt, pin drive, read capture and done. sram_arbiter holds arbitration, last_grant and ack routing.

Test Plan:
- Port 0 read of addr 0x00010 (model holds 0xBEEF), ACCESS_CYCLES=4, req at edge 0 -> ack0 at edge 5, rdata=0xBEEF, CE_N low edges 1-4, WE_N never low.
- Port 1 write of 0x1234 to 0x3FFFF -> WE_N low exactly for cnt 1..2, bus=0x1234 whenever WE_N low, model word updated, ack1 pulses once, bus high-Z afterwards.
- FIXED_PRIO=1, req0 and req1 rise together (0x00001 read, 0x00002 read) -> port 0 served first, port 1 acked ACCESS_CYCLES+2 cycles later.
- FIXED_PRIO=0, both requests held high continuously -> grant order 0,1,0,1 (last_grant resets to 1), each port acked every 2*(ACCESS_CYCLES+2) cycles.
- rst driven low at cnt=2 of a write -> WE_N=1, CE_N=1, bus high-Z and busy=0 asynchronously, no ack; a fresh read after release completes normally.
- Change addr0/wdata0 during ACCESS -> SRAM_ADDRESS and bus keep the values latched at grant.
